// File: rtl/max7219_serial_driver.sv
// MAX7219 3-wire serialiser: one-time init burst after reset, then a full
// display refresh per request, with a single-deep pending request.
module max7219_serial_driver #(
   parameter int CLK_DIV = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [63:0] i_digits,
   input  logic [7:0]  i_decode_mode,
   input  logic [3:0]  i_intensity,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_serial_din,
   output logic        o_serial_load,
   output logic        o_serial_clk
);

   localparam int HP_W = $clog2(CLK_DIV + 1);
   localparam logic [HP_W-1:0] HP_MAX = HP_W'(CLK_DIV);
   localparam logic [HP_W-1:0] HP_ONE = HP_W'(1);
   localparam logic [HP_W-1:0] HP_TWO = HP_W'(2);
   localparam logic [3:0] IDX_LAST = 4'd12;
   localparam logic [3:0] IDX_REFRESH = 4'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_LO, S_HI, S_LATCH, S_DONE
   } state_t;

   state_t state_q, state_n;
   logic [3:0] idx_q, idx_n;
   logic [3:0] bit_q, bit_n;
   logic [HP_W-1:0] hp_q, hp_n;
   logic [15:0] shift_q, shift_n;
   logic init_q, init_n;
   logic pend_q, pend_n;
   logic [63:0] dig_q, dig_n;
   logic [7:0] dec_q, dec_n;
   logic [3:0] int_q, int_n;
   logic go, refresh, next_word, sending;

   function automatic logic [15:0] word_of(
      input logic [3:0]  idx,
      input logic [63:0] dig,
      input logic [7:0]  dec,
      input logic [3:0]  inten
   );
      logic [3:0] k;
      k = idx - 4'd5;
      case (idx)
         4'd0: word_of = 16'h0C01;
         4'd1: word_of = 16'h0F00;
         4'd2: word_of = 16'h0B07;
         4'd3: word_of = {8'h09, dec};
         4'd4: word_of = {8'h0A, 4'h0, inten};
         default: begin
            if (idx <= IDX_LAST)
               word_of = {4'h0, idx - 4'd4, dig[{k[2:0], 3'b000} +: 8]};
            else
               word_of = 16'h0000;
         end
      endcase
   endfunction

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         bit_q   <= '0;
         hp_q    <= '0;
         shift_q <= '0;
         init_q  <= 1'b1;
         pend_q  <= 1'b0;
         dig_q   <= '0;
         dec_q   <= '0;
         int_q   <= '0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         bit_q   <= bit_n;
         hp_q    <= hp_n;
         shift_q <= shift_n;
         init_q  <= init_n;
         pend_q  <= pend_n;
         dig_q   <= dig_n;
         dec_q   <= dec_n;
         int_q   <= int_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      idx_n     = idx_q;
      bit_n     = bit_q;
      hp_n      = hp_q;
      shift_n   = shift_q;
      init_n    = init_q;
      pend_n    = pend_q;
      dig_n     = dig_q;
      dec_n     = dec_q;
      int_n     = int_q;
      go        = 1'b0;
      refresh   = 1'b0;
      next_word = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (init_q) begin
               go     = 1'b1;
               init_n = 1'b0;
               idx_n  = 4'd0;
            end else if (pend_q || i_start) begin
               go      = 1'b1;
               refresh = 1'b1;
            end
         end
         // LOAD is the first low-phase cycle of bit 15
         S_LOAD: begin
            if (CLK_DIV == 1) begin
               state_n = S_HI;
               hp_n    = HP_ONE;
            end else begin
               state_n = S_LO;
               hp_n    = HP_TWO;
            end
         end
         S_LO: begin
            if (hp_q == HP_MAX) begin
               state_n = S_HI;
               hp_n    = HP_ONE;
            end else begin
               hp_n = hp_q + HP_ONE;
            end
         end
         S_HI: begin
            if (hp_q == HP_MAX) begin
               hp_n = HP_ONE;
               if (bit_q == 4'd0) begin
                  state_n = S_LATCH;
               end else begin
                  state_n = S_LO;
                  bit_n   = bit_q - 4'd1;
                  shift_n = {shift_q[14:0], 1'b0};
               end
            end else begin
               hp_n = hp_q + HP_ONE;
            end
         end
         // latch gap is two half periods; bit_q[0] marks the second
         S_LATCH: begin
            if (hp_q == HP_MAX) begin
               hp_n = HP_ONE;
               if (!bit_q[0]) begin
                  bit_n = 4'd1;
               end else if (idx_q == IDX_LAST) begin
                  state_n = S_DONE;
               end else begin
                  idx_n     = idx_q + 4'd1;
                  next_word = 1'b1;
               end
            end else begin
               hp_n = hp_q + HP_ONE;
            end
         end
         S_DONE: begin
            if (pend_q || i_start) begin
               go      = 1'b1;
               refresh = 1'b1;
            end else begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (refresh) begin
         idx_n  = IDX_REFRESH;
         pend_n = 1'b0;
      end else if (i_start) begin
         pend_n = 1'b1;
      end
      if (go) begin
         dig_n = i_digits;
         dec_n = i_decode_mode;
         int_n = i_intensity;
      end
      if (go || next_word) begin
         state_n = S_LOAD;
         bit_n   = 4'd15;
         shift_n = word_of(idx_n, dig_n, dec_n, int_n);
      end
   end

   assign sending = (state_q == S_LOAD) || (state_q == S_LO) ||
                    (state_q == S_HI);

   assign o_serial_load = !sending;
   assign o_serial_clk  = (state_q == S_HI);
   assign o_serial_din  = sending && shift_q[15];
   assign o_done        = (state_q == S_DONE);
   assign o_busy        = ((state_q != S_IDLE) && (state_q != S_DONE)) ||
                          init_q || pend_q || i_start;

endmodule

// File: tb/tb_max7219_serial_driver.sv
// Bench for max7219_serial_driver: three instances (CLK_DIV 2, 1, 5) each
// watched by a mock MAX7219 receiver with pin-timing checks.
module tb_max7219_serial_driver;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  dm;
      logic [3:0]  it;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [2:0] start = '0;
   logic [63:0] digits = '0;
   logic [7:0] dec = '0;
   logic [3:0] inten = '0;
   logic [2:0] busy, done, sdin, sload, sclk;

   int n_pass = 0;
   int n_tot = 0;
   logic [15:0] wlog [3][512];
   int wcnt [3] = '{0, 0, 0};
   int rd [3] = '{0, 0, 0};
   logic [7:0] mreg [3][16];
   logic [15:0] eq [$];

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

      max7219_serial_driver #(.CLK_DIV(DIV)) u_dut (
         .i_clk         (clk),
         .i_reset       (rst),
         .i_start       (start[g]),
         .i_digits      (digits),
         .i_decode_mode (dec),
         .i_intensity   (inten),
         .o_busy        (busy[g]),
         .o_done        (done[g]),
         .o_serial_din  (sdin[g]),
         .o_serial_load (sload[g]),
         .o_serial_clk  (sclk[g])
      );

      // mock receiver: shifts on clk rise, latches on load rise
      initial begin
         logic p_load, p_clk, p_din;
         logic [15:0] sh;
         int nb, hi;
         p_load = 1'b1; p_clk = 1'b0; p_din = 1'b0;
         sh = '0; nb = 0; hi = 1000;
         forever begin
            @(negedge clk);
            if (rst) begin
               nb = 0;
               hi = 1000;
            end else begin
               if (sclk[g] && !p_clk && !sload[g]) begin
                  chk($sformatf("din_stable div%0d", DIV),
                      64'(sdin[g]), 64'(p_din));
                  sh = {sh[14:0], sdin[g]};
                  nb++;
               end
               if (sload[g] && !p_load) begin
                  chk($sformatf("rises_per_word div%0d", DIV),
                      64'(nb), 64'd16);
                  chk($sformatf("latch_clk_din div%0d", DIV),
                      64'({sclk[g], sdin[g]}), 64'd0);
                  if (wcnt[g] < 512) begin
                     wlog[g][wcnt[g]] = sh;
                     wcnt[g]++;
                  end
                  mreg[g][sh[11:8]] = sh[7:0];
                  hi = 0;
               end
               if (!sload[g] && p_load) begin
                  chk($sformatf("load_gap div%0d", DIV),
                      64'(hi >= 2 * DIV), 64'd1);
                  chk($sformatf("fall_clk div%0d", DIV),
                      64'(sclk[g]), 64'd0);
                  nb = 0;
               end
               if (sload[g]) hi++;
            end
            p_load = sload[g];
            p_clk  = sclk[g];
            p_din  = sdin[g];
         end
      end
   end

   task automatic add_seq(input bit init, input logic [63:0] d,
                          input logic [7:0] dm, input logic [3:0] it);
      if (init) begin
         eq.push_back(16'h0C01);
         eq.push_back(16'h0F00);
         eq.push_back(16'h0B07);
      end
      eq.push_back({8'h09, dm});
      eq.push_back({8'h0A, 4'h0, it});
      for (int k = 0; k < 8; k++)
         eq.push_back({8'(k + 1), d[8*k +: 8]});
   endtask

   task automatic cmp_words(input int g, input string nm);
      chk({nm, " count"}, 64'(wcnt[g] - rd[g]), 64'(eq.size()));
      for (int i = 0; i < eq.size(); i++)
         chk($sformatf("%s[%0d]", nm, i),
             64'(wlog[g][(rd[g] + i) % 512]), 64'(eq[i]));
      rd[g] = wcnt[g];
      eq.delete();
   endtask

   task automatic disp(input int g, input logic [63:0] d,
                       input logic [7:0] dm, input logic [3:0] it);
      logic [63:0] a;
      for (int k = 0; k < 8; k++) a[8*k +: 8] = mreg[g][k + 1];
      chk($sformatf("display digits g%0d", g), a, d);
      chk($sformatf("display cfg g%0d", g),
          64'({mreg[g][9], mreg[g][10], mreg[g][11], mreg[g][12],
               mreg[g][15]}),
          64'({dm, 4'h0, it, 8'h07, 8'h01, 8'h00}));
   endtask

   task automatic wait_done(input int g, output int lat, output bit dropped);
      int t;
      t = 0;
      lat = 0;
      dropped = 1'b0;
      while (sload[g] && t < 6000) begin
         @(negedge clk);
         t++;
      end
      while (!done[g] && lat < 6000) begin
         @(negedge clk);
         lat++;
         if (!busy[g] && !done[g]) dropped = 1'b1;
      end
      chk($sformatf("done seen g%0d", g), 64'(done[g]), 64'd1);
   endtask

   task automatic wait_idle(input int g);
      int t;
      t = 0;
      while (busy[g] && t < 8000) begin
         @(negedge clk);
         t++;
      end
      chk($sformatf("idle g%0d", g), 64'(busy[g]), 64'd0);
   endtask

   task automatic pulse(input int g);
      @(negedge clk);
      start[g] = 1'b1;
      #1 chk($sformatf("busy on start g%0d", g), 64'(busy[g]), 64'd1);
      @(negedge clk);
      start[g] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl [7];
      int lat;
      bit dr;
      logic [63:0] da, db;
      logic [3:0] ia, ib;

      digits = 64'h0807060504030201;
      dec    = 8'hFF;
      inten  = 4'h8;
      #1 rst = 1'b1;
      #1;
      chk("reset load", 64'(sload[0]), 64'd1);
      chk("reset clk", 64'(sclk[0]), 64'd0);
      chk("reset din", 64'(sdin[0]), 64'd0);
      chk("reset busy", 64'(busy[0]), 64'd1);
      chk("reset done", 64'(done[0]), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      add_seq(1'b1, digits, dec, inten);
      wait_done(0, lat, dr);
      chk("init latency", 64'(lat), 64'd884);
      cmp_words(0, "init words");
      disp(0, digits, dec, inten);
      @(negedge clk);
      chk("done one cycle", 64'(done[0]), 64'd0);
      chk("idle after init", 64'(busy[0]), 64'd0);
      for (int g = 1; g < 3; g++) begin
         wait_idle(g);
         add_seq(1'b1, digits, dec, inten);
         cmp_words(g, "init words other div");
         disp(g, digits, dec, inten);
      end

      tbl[0] = '{64'h000000000000000F, 8'h00, 4'h3, 680};
      tbl[1] = '{64'h0F0E0D0C0B0A0908, 8'h0F, 4'hF, 680};
      tbl[2] = '{64'h0, 8'hFF, 4'h0, 680};
      for (int i = 3; i < 7; i++)
         tbl[i] = '{{$urandom, $urandom}, 8'($urandom), 4'($urandom), 680};
      for (int i = 0; i < 7; i++) begin
         digits = tbl[i].d;
         dec    = tbl[i].dm;
         inten  = tbl[i].it;
         chk("idle before refresh", 64'(busy[0]), 64'd0);
         pulse(0);
         wait_done(0, lat, dr);
         chk($sformatf("refresh latency v%0d", i), 64'(lat), 64'(tbl[i].lat));
         add_seq(1'b0, tbl[i].d, tbl[i].dm, tbl[i].it);
         cmp_words(0, $sformatf("refresh words v%0d", i));
         disp(0, tbl[i].d, tbl[i].dm, tbl[i].it);
         @(negedge clk);
         chk("refresh done one cycle", 64'(done[0]), 64'd0);
      end

      digits = {$urandom, $urandom};
      pulse(0);
      repeat (40) @(negedge clk);
      pulse(0);
      repeat (100) @(negedge clk);
      pulse(0);
      pulse(0);
      wait_done(0, lat, dr);
      chk("pending keeps busy at done", 64'(busy[0]), 64'd1);
      wait_done(0, lat, dr);
      chk("back-to-back latency", 64'(lat), 64'd680);
      chk("busy never dropped", 64'(dr), 64'd0);
      add_seq(1'b0, digits, dec, inten);
      add_seq(1'b0, digits, dec, inten);
      cmp_words(0, "collapsed pending words");
      @(negedge clk);
      chk("idle after pending", 64'(busy[0]), 64'd0);

      da = {$urandom, $urandom};
      db = ~da;
      ia = 4'h5;
      ib = 4'hC;
      digits = da;
      inten  = ia;
      pulse(0);
      repeat (100) @(negedge clk);
      digits = db;
      inten  = ib;
      wait_done(0, lat, dr);
      add_seq(1'b0, da, dec, ia);
      cmp_words(0, "snapshot old");
      pulse(0);
      wait_done(0, lat, dr);
      add_seq(1'b0, db, dec, ib);
      cmp_words(0, "snapshot new");
      disp(0, db, dec, ib);

      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (7 * 68 + 20) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async reset load", 64'(sload[0]), 64'd1);
      chk("async reset clk", 64'(sclk[0]), 64'd0);
      chk("async reset din", 64'(sdin[0]), 64'd0);
      chk("async reset busy", 64'(busy[0]), 64'd1);
      for (int g = 0; g < 3; g++) rd[g] = wcnt[g];
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_done(0, lat, dr);
      chk("reinit latency", 64'(lat), 64'd884);
      add_seq(1'b1, digits, dec, inten);
      cmp_words(0, "reinit words");
      disp(0, digits, dec, inten);
      for (int g = 1; g < 3; g++) begin
         wait_idle(g);
         add_seq(1'b1, digits, dec, inten);
         cmp_words(g, "reinit words other div");
      end

      digits = {$urandom, $urandom};
      inten  = 4'($urandom);
      pulse(1);
      pulse(2);
      for (int g = 1; g < 3; g++) begin
         wait_idle(g);
         add_seq(1'b0, digits, dec, inten);
         cmp_words(g, "refresh words other div");
         disp(g, digits, dec, inten);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
